// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer: shadow E/M/W control pipeline, forwarding selects,
// load-use / PC-write / multiply stalls and flushes, and the multiplier handshake.
`default_nettype none

module hazard_sequencer #(
  parameter int MUL_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3D,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       PCSD,
  input  logic       MulD,
  input  logic       CondExE,
  input  logic       BranchTakenE,
  input  logic       MulDone,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       PCWrPendingF,
  output logic       MulStart,
  output logic       MulErr
);

  localparam int CNT_W = $clog2(MUL_MAX + 1);

  typedef enum logic {IDLE, BUSY} mul_state_t;

  // Stage suffixes: _p0 = Execute, _p1 = Memory, _p2 = Writeback.
  logic [3:0] ra1_p0, ra2_p0, wa3_p0;
  logic       regwrite_p0, memtoreg_p0, pcs_p0, mul_p0;
  logic [3:0] wa3_p1;
  logic       regwrite_p1, pcs_p1;
  logic [3:0] wa3_p2;
  logic       regwrite_p2, pcs_p2;

  mul_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic mul_err_q;
  logic mul_stall, mul_start, timeout;
  logic ldr_stall;

  // Decode -> Execute boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_p0      <= '0;
      ra2_p0      <= '0;
      wa3_p0      <= '0;
      regwrite_p0 <= 1'b0;
      memtoreg_p0 <= 1'b0;
      pcs_p0      <= 1'b0;
      mul_p0      <= 1'b0;
    end else if (FlushE) begin
      ra1_p0      <= '0;
      ra2_p0      <= '0;
      wa3_p0      <= '0;
      regwrite_p0 <= 1'b0;
      memtoreg_p0 <= 1'b0;
      pcs_p0      <= 1'b0;
      mul_p0      <= 1'b0;
    end else if (!StallE) begin
      ra1_p0      <= RA1D;
      ra2_p0      <= RA2D;
      wa3_p0      <= WA3D;
      regwrite_p0 <= RegWriteD;
      memtoreg_p0 <= MemtoRegD;
      pcs_p0      <= PCSD;
      mul_p0      <= MulD;
    end
  end

  // Execute -> Memory -> Writeback boundaries
  always_ff @(posedge clk) begin
    if (reset || StallE) begin
      wa3_p1      <= '0;
      regwrite_p1 <= 1'b0;
      pcs_p1      <= 1'b0;
    end else begin
      wa3_p1      <= wa3_p0;
      regwrite_p1 <= regwrite_p0 & CondExE;
      pcs_p1      <= pcs_p0 & CondExE;
    end
    if (reset) begin
      wa3_p2      <= '0;
      regwrite_p2 <= 1'b0;
      pcs_p2      <= 1'b0;
    end else begin
      wa3_p2      <= wa3_p1;
      regwrite_p2 <= regwrite_p1;
      pcs_p2      <= pcs_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mul_err_q <= mul_err_q | timeout;
    end
  end

  // A predicated-off MUL in Execute never leaves IDLE and passes as a no-op.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_start = 1'b0;
    mul_stall = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (mul_p0 && CondExE) begin
          mul_start = 1'b1;
          mul_stall = 1'b1;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (MulDone) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(MUL_MAX)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else begin
          mul_stall = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (regwrite_p1 && (ra1_p0 == wa3_p1))      ForwardAE = 2'b10;
    else if (regwrite_p2 && (ra1_p0 == wa3_p2)) ForwardAE = 2'b01;
    if (regwrite_p1 && (ra2_p0 == wa3_p1))      ForwardBE = 2'b10;
    else if (regwrite_p2 && (ra2_p0 == wa3_p2)) ForwardBE = 2'b01;
  end

  // Load-use check deliberately ignores CondExE.
  assign ldr_stall    = memtoreg_p0 & regwrite_p0 & ((RA1D == wa3_p0) | (RA2D == wa3_p0));
  assign PCWrPendingF = PCSD | pcs_p0 | pcs_p1;
  assign StallF       = ldr_stall | PCWrPendingF | mul_stall;
  assign StallD       = ldr_stall | mul_stall;
  assign StallE       = mul_stall;
  assign FlushE       = (ldr_stall | BranchTakenE) & ~mul_stall;
  assign FlushD       = PCWrPendingF | pcs_p2 | BranchTakenE;
  assign MulStart     = mul_start;
  assign MulErr       = mul_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_hazard_sequencer;
  localparam int MUL_MAX = 16;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic RegWriteD, MemtoRegD, PCSD, MulD;
  logic CondExE, BranchTakenE, MulDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, PCWrPendingF, MulStart, MulErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MUL_MAX(MUL_MAX)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSD(PCSD), .MulD(MulD),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .MulDone(MulDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .PCWrPendingF(PCWrPendingF),
    .MulStart(MulStart), .MulErr(MulErr)
  );

  function automatic logic [13:0] outs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
            PCWrPendingF, MulStart, MulErr};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                       input logic rw, input logic mr, input logic pcs, input logic mul);
    RA1D = a1; RA2D = a2; WA3D = w;
    RegWriteD = rw; MemtoRegD = mr; PCSD = pcs; MulD = mul;
  endtask

  task automatic clr_d();
    set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_d();
    CondExE = 1'b0; BranchTakenE = 1'b0; MulDone = 1'b0;
    next();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_d();
    CondExE = 1'b0; BranchTakenE = 1'b0; MulDone = 1'b0;
    next(); next();
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 14'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", outs(), 14'h0);
    end
    next();
    checks++;
    if (outs() !== 14'h0) begin
      errors++; $display("FAIL idle_outputs: got %h expected %h", outs(), 14'h0);
    end
  endtask

  task automatic test_forward();
    logic [3:0] got;
    do_reset();
    CondExE = 1'b1;
    set_d(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0); next();   // ADD R1
    set_d(4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0); next();   // SUB R2,R1,R3
    set_d(4'd1, 4'd7, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    got = {ForwardAE, ForwardBE}; checks++;
    if (got !== 4'b1000) begin errors++; $display("FAIL fwd_from_m: got %b expected %b", got, 4'b1000); end
    next();
    set_d(4'd5, 4'd2, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    got = {ForwardAE, ForwardBE}; checks++;
    if (got !== 4'b0100) begin errors++; $display("FAIL fwd_from_w: got %b expected %b", got, 4'b0100); end
    next();
    set_d(4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    got = {ForwardAE, ForwardBE}; checks++;
    if (got !== 4'b0001) begin errors++; $display("FAIL fwd_b_from_w: got %b expected %b", got, 4'b0001); end
    next();
    set_d(4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0); next();
    set_d(4'd9, 4'd9, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0); next();
    set_d(4'd0, 4'd0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    got = {ForwardAE, ForwardBE}; checks++;
    if (got !== 4'b1010) begin errors++; $display("FAIL fwd_m_priority: got %b expected %b", got, 4'b1010); end
    next();
    CondExE = 1'b0;
    set_d(4'd12, 4'd12, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0); next();
    CondExE = 1'b1;
    clr_d(); #1;
    got = {ForwardAE, ForwardBE}; checks++;
    if (got !== 4'b0000) begin errors++; $display("FAIL fwd_cond_fail: got %b expected %b", got, 4'b0000); end
    next();
  endtask

  task automatic test_load_use();
    logic [4:0] st;
    logic [3:0] fw;
    do_reset();
    CondExE = 1'b1;
    set_d(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0); next();   // LDR R4
    set_d(4'd4, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;       // ADD R5,R4,R4
    st = {StallF, StallD, StallE, FlushE, FlushD}; checks++;
    if (st !== 5'b11010) begin errors++; $display("FAIL ldr_stall: got %b expected %b", st, 5'b11010); end
    next(); #1;
    st = {StallF, StallD, StallE, FlushE, FlushD}; checks++;
    if (st !== 5'b00000) begin errors++; $display("FAIL ldr_release: got %b expected %b", st, 5'b00000); end
    next();
    clr_d(); #1;
    fw = {ForwardAE, ForwardBE}; checks++;
    if (fw !== 4'b0101) begin errors++; $display("FAIL ldr_fwd_w: got %b expected %b", fw, 4'b0101); end
    next();
    set_d(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0); next();
    CondExE = 1'b0;
    set_d(4'd0, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    st = {StallF, StallD, StallE, FlushE, FlushD}; checks++;
    if (st !== 5'b11010) begin errors++; $display("FAIL ldr_stall_condfail: got %b expected %b", st, 5'b11010); end
    next();
    CondExE = 1'b1;
  endtask

  task automatic test_pc_write();
    logic [3:0] got, exp;
    do_reset();
    CondExE = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
      else clr_d();
      #1;
      exp = {(k < 3) ? 1'b1 : 1'b0, (k < 3) ? 1'b1 : 1'b0, (k < 4) ? 1'b1 : 1'b0, 1'b0};
      got = {PCWrPendingF, StallF, FlushD, StallD};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pc_write_cycle%0d: got %b expected %b", k, got, exp);
      end
      next();
    end
  endtask

  task automatic test_mul();
    int stalls, starts;
    stalls = 0; starts = 0;
    do_reset();
    CondExE = 1'b1;
    set_d(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1); next();   // MUL R3,R1,R2
    set_d(4'd3, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);           // ADD R6,R3,R0
    for (int k = 1; k <= 7; k++) begin
      MulDone = (k == 6);
      #1;
      if (StallE && StallD && StallF) stalls++;
      if (MulStart) starts++;
      if (k == 7) begin
        checks++;
        if (ForwardAE !== 2'b10) begin
          errors++; $display("FAIL mul_follower_fwd: got %b expected %b", ForwardAE, 2'b10);
        end
      end
      next();
    end
    MulDone = 1'b0;
    checks++;
    if (stalls != 5) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected %0d", stalls, 5); end
    checks++;
    if (starts != 1) begin errors++; $display("FAIL mul_start_pulses: got %0d expected %0d", starts, 1); end
    checks++;
    if (MulErr !== 1'b0) begin errors++; $display("FAIL mul_no_err: got %b expected %b", MulErr, 1'b0); end
  endtask

  task automatic test_mul_timeout();
    int stalls, starts;
    stalls = 0; starts = 0;
    do_reset();
    CondExE = 1'b1;
    set_d(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1); next();
    clr_d();
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (StallE) stalls++;
      if (MulStart) starts++;
      next();
    end
    checks++;
    if (stalls != MUL_MAX + 1) begin
      errors++; $display("FAIL timeout_stall_cycles: got %0d expected %0d", stalls, MUL_MAX + 1);
    end
    checks++;
    if (starts != 1) begin errors++; $display("FAIL timeout_start_pulses: got %0d expected %0d", starts, 1); end
    next(); next();
    checks++;
    if (MulErr !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b expected %b", MulErr, 1'b1); end
    set_d(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1); next();
    clr_d();
    CondExE = 1'b0;
    #1;
    checks++;
    if ({MulStart, StallE} !== 2'b00) begin
      errors++; $display("FAIL mul_condfail_noop: got %b expected %b", {MulStart, StallE}, 2'b00);
    end
    next();
    checks++;
    if (MulErr !== 1'b1) begin errors++; $display("FAIL err_held: got %b expected %b", MulErr, 1'b1); end
  endtask

  task automatic test_reset_busy();
    CondExE = 1'b1;
    set_d(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1); next();
    clr_d();
    next(); next(); next();   // start cycle, then two BUSY cycles
    reset = 1'b1;
    next();
    reset = 1'b0;
    CondExE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (outs() !== 14'h0) begin
        errors++; $display("FAIL reset_busy_cycle%0d: got %h expected %h", k, outs(), 14'h0);
      end
      next();
    end
  endtask

  // Reference model: instructions occupy E/M/W slots; the multiply is tracked as
  // the number of Execute cycles it has held so far.
  typedef struct packed {
    logic [3:0] ra1, ra2, wa3;
    logic rw, mr, pcs, mul;
  } einst_t;
  typedef struct packed {
    logic [3:0] wa3;
    logic rw, pcs;
  } winst_t;

  task automatic test_random(input int n, input int done_pct);
    einst_t me, ne;
    winst_t mm, mw;
    bit busy, err, ldr, pcw, mstall, mstart;
    int held;
    logic [1:0] fa, fb;
    logic [13:0] exp;
    do_reset();
    me = '0; mm = '0; mw = '0; busy = 0; err = 0; held = 0;
    for (int c = 0; c < n; c++) begin
      set_d(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8);
      CondExE      = $urandom_range(0, 99) < 80;
      BranchTakenE = $urandom_range(0, 99) < 5;
      MulDone      = $urandom_range(0, 99) < done_pct;
      #1;
      ldr = me.mr && me.rw && (RA1D == me.wa3 || RA2D == me.wa3);
      pcw = PCSD || me.pcs || mm.pcs;
      mstart = !busy && me.mul && CondExE;
      mstall = mstart || (busy && !MulDone && held < MUL_MAX + 1);
      fa = (mm.rw && mm.wa3 == me.ra1) ? 2'b10 : (mw.rw && mw.wa3 == me.ra1) ? 2'b01 : 2'b00;
      fb = (mm.rw && mm.wa3 == me.ra2) ? 2'b10 : (mw.rw && mw.wa3 == me.ra2) ? 2'b01 : 2'b00;
      exp = {fa, fb, ldr | pcw | mstall, ldr | mstall, mstall,
             pcw | mw.pcs | BranchTakenE, (ldr | BranchTakenE) & !mstall, pcw, mstart, err};
      checks++;
      if (outs() !== exp) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", c, outs(), exp);
      end
      if (mstart) begin
        busy = 1; held = 1;
      end else if (busy) begin
        if (mstall) held++;
        else begin
          if (!MulDone) err = 1;
          busy = 0;
        end
      end
      mw = mm;
      mm = mstall ? '0 : winst_t'{me.wa3, me.rw & CondExE, me.pcs & CondExE};
      ne = einst_t'{RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSD, MulD};
      if ((ldr || BranchTakenE) && !mstall) me = '0;
      else if (!mstall) me = ne;
      next();
    end
  endtask

  initial begin
    reset = 1'b1;
    clr_d();
    CondExE = 1'b0; BranchTakenE = 1'b0; MulDone = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_pc_write();
    test_mul();
    test_mul_timeout();
    test_reset_busy();
    test_random(1500, 20);
    test_random(600, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
